// File: rtl/tmr_regfile_scrub_if.sv
// rtl/tmr_regfile_scrub_if.sv - register-file, fault-injection and scrubber status bundle
interface tmr_regfile_scrub_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             we3;
  logic [4:0]       ra1;
  logic [4:0]       ra2;
  logic [4:0]       wa3;
  logic [WIDTH-1:0] wd3;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             scrub_en;
  logic             inj_en;
  logic [1:0]       inj_copy;
  logic [4:0]       inj_addr;
  logic [WIDTH-1:0] inj_mask;
  logic [4:0]       scrub_addr;
  logic             corrected;
  logic [CNT_W-1:0] err_count;
  logic [2:0]       err_copy_mask;

  modport master (
    output we3, ra1, ra2, wa3, wd3, scrub_en, inj_en, inj_copy, inj_addr, inj_mask,
    input  rd1, rd2, scrub_addr, corrected, err_count, err_copy_mask
  );

  modport slave (
    input  we3, ra1, ra2, wa3, wd3, scrub_en, inj_en, inj_copy, inj_addr, inj_mask,
    output rd1, rd2, scrub_addr, corrected, err_count, err_copy_mask
  );
endinterface

// File: rtl/tmr_regfile_scrub.sv
// rtl/tmr_regfile_scrub.sv - triple-redundant 32x3-port register file with voting reads and background scrub
module tmr_regfile_scrub #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  tmr_regfile_scrub_if.slave bus
);
  typedef enum logic {SCAN, FIX} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mem_q [3][32];
  logic [4:0]       scrub_addr_q;
  logic [WIDTH-1:0] fix_val_q;
  logic [2:0]       fix_mask_q;
  logic             corrected_q;
  logic [CNT_W-1:0] err_count_q;
  logic [2:0]       err_copy_mask_q;

  logic [WIDTH-1:0] scrub_vote;
  logic [2:0]       scrub_mism;
  logic             wr_hit;
  logic             inj_hit;
  logic             fix_commit;
  logic [4:0]       next_addr;

  function automatic logic [WIDTH-1:0] vote(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign bus.rd1 = (bus.ra1 == 5'd0) ? '0
                 : vote(mem_q[0][bus.ra1], mem_q[1][bus.ra1], mem_q[2][bus.ra1]);
  assign bus.rd2 = (bus.ra2 == 5'd0) ? '0
                 : vote(mem_q[0][bus.ra2], mem_q[1][bus.ra2], mem_q[2][bus.ra2]);

  assign bus.scrub_addr    = scrub_addr_q;
  assign bus.corrected     = corrected_q;
  assign bus.err_count     = err_count_q;
  assign bus.err_copy_mask = err_copy_mask_q;

  // Vote the entry under the scrubber and detect traffic that collides with a pending repair
  always_comb begin
    scrub_mism = '0;
    scrub_vote = vote(mem_q[0][scrub_addr_q], mem_q[1][scrub_addr_q], mem_q[2][scrub_addr_q]);
    for (int k = 0; k < 3; k++) begin
      scrub_mism[k] = (mem_q[k][scrub_addr_q] != scrub_vote);
    end
    wr_hit     = bus.we3 && (bus.wa3 == scrub_addr_q);
    inj_hit    = bus.inj_en && (bus.inj_addr == scrub_addr_q);
    fix_commit = (state_q == FIX) && !wr_hit && !inj_hit;
    next_addr  = (scrub_addr_q == 5'd31) ? 5'd1 : scrub_addr_q + 5'd1;
  end

  // Storage: repair, then functional write, then injection XOR layered on top of the written data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        for (int a = 0; a < 32; a++) begin
          mem_q[k][a] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (fix_commit && fix_mask_q[k]) begin
          mem_q[k][scrub_addr_q] <= fix_val_q;
        end
        if (bus.we3 && (bus.wa3 != 5'd0)) begin
          mem_q[k][bus.wa3] <= bus.wd3;
        end
        if (bus.inj_en && (bus.inj_addr != 5'd0) && (bus.inj_copy == 2'(k))) begin
          mem_q[k][bus.inj_addr] <= ((bus.we3 && (bus.wa3 == bus.inj_addr))
                                     ? bus.wd3 : mem_q[k][bus.inj_addr]) ^ bus.inj_mask;
        end
      end
    end
  end

  // Scrubber FSM: SCAN walks 1..31, FIX spends one cycle committing or dropping the repair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= SCAN;
      scrub_addr_q    <= 5'd1;
      fix_val_q       <= '0;
      fix_mask_q      <= '0;
      corrected_q     <= 1'b0;
      err_count_q     <= '0;
      err_copy_mask_q <= '0;
    end else begin
      corrected_q <= 1'b0;
      case (state_q)
        SCAN: begin
          if (bus.scrub_en) begin
            if ((scrub_mism == 3'b000) || wr_hit) begin
              scrub_addr_q <= next_addr;
            end else begin
              fix_val_q  <= scrub_vote;
              fix_mask_q <= scrub_mism;
              state_q    <= FIX;
            end
          end
        end
        FIX: begin
          if (fix_commit) begin
            corrected_q     <= 1'b1;
            err_copy_mask_q <= err_copy_mask_q | fix_mask_q;
            if (err_count_q != '1) begin
              err_count_q <= err_count_q + CNT_W'(1);
            end
          end
          scrub_addr_q <= next_addr;
          state_q      <= SCAN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tmr_regfile_scrub.sv
// tb/tb_tmr_regfile_scrub.sv - directed self-checking bench for tmr_regfile_scrub
module tb_tmr_regfile_scrub;
  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  int   vectors = 0;
  int   miscompares = 0;
  int   pulses;
  int   n;

  always #5 clk = ~clk;

  tmr_regfile_scrub_if #(.WIDTH(32), .CNT_W(16)) b0 ();
  tmr_regfile_scrub_if #(.WIDTH(32), .CNT_W(2))  b1 ();

  tmr_regfile_scrub #(.WIDTH(32), .CNT_W(16)) u0 (.clk(clk), .reset(rst0), .bus(b0));
  tmr_regfile_scrub #(.WIDTH(32), .CNT_W(2))  u1 (.clk(clk), .reset(rst1), .bus(b1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b0.we3 = 0; b0.ra1 = 0; b0.ra2 = 0; b0.wa3 = 0; b0.wd3 = 0; b0.scrub_en = 0;
    b0.inj_en = 0; b0.inj_copy = 0; b0.inj_addr = 0; b0.inj_mask = 0;
    b1.we3 = 0; b1.ra1 = 0; b1.ra2 = 0; b1.wa3 = 0; b1.wd3 = 0; b1.scrub_en = 0;
    b1.inj_en = 0; b1.inj_copy = 0; b1.inj_addr = 0; b1.inj_mask = 0;
    rst0 = 1; rst1 = 1;
    #1 rst0 = 0; rst1 = 0;
    #1;
    // reset state, no clock edge yet
    chk("rst_rd1", b0.rd1, 32'h0);
    chk("rst_rd2", b0.rd2, 32'h0);
    chk("rst_scrub_addr", 32'(b0.scrub_addr), 32'd1);
    chk("rst_err_count", 32'(b0.err_count), 32'd0);
    chk("rst_err_mask", 32'(b0.err_copy_mask), 32'd0);
    chk("rst_corrected", 32'(b0.corrected), 32'd0);
    repeat (2) tick();
    rst0 = 1; rst1 = 1;
    tick();
    chk("idle_scrub_addr", 32'(b0.scrub_addr), 32'd1);

    // functional write and combinational reads
    b0.we3 = 1; b0.wa3 = 5; b0.wd3 = 32'hDEADBEEF;
    tick();
    b0.we3 = 0; b0.ra1 = 5; b0.ra2 = 0;
    #1;
    chk("rd1_r5", b0.rd1, 32'hDEADBEEF);
    chk("rd2_r0", b0.rd2, 32'h0);
    b0.we3 = 1; b0.wa3 = 0; b0.wd3 = 32'hFFFFFFFF;
    tick();
    b0.we3 = 0;
    #1;
    chk("rd2_r0_after_w0", b0.rd2, 32'h0);

    // single-copy fault masked by the vote, then repaired by a sweep
    b0.inj_en = 1; b0.inj_copy = 1; b0.inj_addr = 5; b0.inj_mask = 32'h0000FFFF;
    tick();
    b0.inj_en = 0;
    #1;
    chk("rd1_masked", b0.rd1, 32'hDEADBEEF);
    chk("hold_scrub_addr", 32'(b0.scrub_addr), 32'd1);
    b0.scrub_en = 1;
    pulses = 0;
    for (int i = 0; i < 62; i++) begin
      tick();
      if (b0.corrected === 1'b1) pulses++;
    end
    b0.scrub_en = 0;
    chk("sweep1_pulses", 32'(pulses), 32'd1);
    chk("sweep1_err_count", 32'(b0.err_count), 32'd1);
    chk("sweep1_err_mask", 32'(b0.err_copy_mask), 32'b010);
    chk("sweep1_scrub_addr", 32'(b0.scrub_addr), 32'd31);
    b0.inj_en = 1; b0.inj_copy = 2; b0.inj_addr = 5; b0.inj_mask = 32'h0000FFFF;
    tick();
    b0.inj_en = 0;
    #1;
    chk("rd1_copy1_repaired", b0.rd1, 32'hDEADBEEF);
    b0.we3 = 1; b0.wa3 = 5; b0.wd3 = 32'hDEADBEEF;
    tick();
    b0.we3 = 0;

    // functional write during FIX drops the repair
    b0.inj_en = 1; b0.inj_copy = 0; b0.inj_addr = 7; b0.inj_mask = 32'h1;
    tick();
    b0.inj_en = 0; b0.ra1 = 7; b0.scrub_en = 1;
    n = 0;
    while (b0.scrub_addr !== 5'd7 && n < 64) begin
      tick();
      n++;
    end
    chk("reach_addr7", 32'(b0.scrub_addr), 32'd7);
    tick();
    chk("fix_hold_addr7", 32'(b0.scrub_addr), 32'd7);
    chk("fix_entry_corrected", 32'(b0.corrected), 32'd0);
    b0.we3 = 1; b0.wa3 = 7; b0.wd3 = 32'h12345678;
    tick();
    b0.we3 = 0;
    #1;
    chk("conflict_corrected", 32'(b0.corrected), 32'd0);
    chk("conflict_err_count", 32'(b0.err_count), 32'd1);
    chk("conflict_rd1", b0.rd1, 32'h12345678);
    chk("conflict_scrub_addr", 32'(b0.scrub_addr), 32'd8);
    pulses = 0;
    for (int i = 0; i < 62; i++) begin
      tick();
      if (b0.corrected === 1'b1) pulses++;
    end
    b0.scrub_en = 0;
    chk("clean_sweep_pulses", 32'(pulses), 32'd0);
    chk("clean_sweep_addr", 32'(b0.scrub_addr), 32'd8);

    // asynchronous reset while in FIX
    b0.inj_en = 1; b0.inj_copy = 2; b0.inj_addr = 8; b0.inj_mask = 32'hF0;
    tick();
    b0.inj_en = 0; b0.ra1 = 8;
    #1;
    chk("rd1_r8_masked", b0.rd1, 32'h0);
    b0.scrub_en = 1;
    tick();
    b0.scrub_en = 0;
    chk("fix_hold_addr8", 32'(b0.scrub_addr), 32'd8);
    #2 rst0 = 0;
    #1;
    chk("midfix_rst_addr", 32'(b0.scrub_addr), 32'd1);
    chk("midfix_rst_err_count", 32'(b0.err_count), 32'd0);
    chk("midfix_rst_err_mask", 32'(b0.err_copy_mask), 32'd0);
    chk("midfix_rst_corrected", 32'(b0.corrected), 32'd0);
    b0.ra1 = 7;
    #1;
    chk("midfix_rst_rd1_r7", b0.rd1, 32'h0);
    tick();
    rst0 = 1;
    tick();
    chk("post_midfix_corrected", 32'(b0.corrected), 32'd0);
    chk("post_midfix_addr", 32'(b0.scrub_addr), 32'd1);

    // saturating 2-bit counter on the second instance
    b1.inj_en = 1; b1.inj_copy = 0; b1.inj_addr = 1; b1.inj_mask = 32'h1;
    tick();
    b1.inj_copy = 1; b1.inj_addr = 2; b1.inj_mask = 32'h2;
    tick();
    b1.inj_copy = 2; b1.inj_addr = 3; b1.inj_mask = 32'h4;
    tick();
    b1.inj_copy = 0; b1.inj_addr = 4; b1.inj_mask = 32'h8;
    tick();
    b1.inj_copy = 3; b1.inj_addr = 6; b1.inj_mask = 32'hFFFFFFFF;
    tick();
    b1.inj_en = 0; b1.ra1 = 4;
    #1;
    chk("sat_rd1_r4", b1.rd1, 32'h0);
    b1.scrub_en = 1;
    pulses = 0;
    for (int i = 0; i < 62; i++) begin
      tick();
      if (b1.corrected === 1'b1) pulses++;
    end
    b1.scrub_en = 0;
    chk("sat_pulses", 32'(pulses), 32'd4);
    chk("sat_err_count", 32'(b1.err_count), 32'd3);
    chk("sat_err_mask", 32'(b1.err_copy_mask), 32'b111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench did not finish");
  end
endmodule

// File: doc/tmr_regfile_scrub.md
Name: tmr_regfile_scrub

Overview:
- Triple-modular-redundant replacement for the 32-entry, 3-port MIPS register file.
- Stores three copies of each register and returns a bitwise 2-of-3 majority vote on both read ports.
- A background scrubber walks the registers, detects copies that disagree with the vote, and writes the voted value back into them. This is the storage-side counterpart to the redundant, voted ALU: the ALU masks faulty computation, this block repairs faulty state.
- A fault-injection port exists for verification.

Parameters:
- WIDTH, 32: data width of each register.
- CNT_W, 16: width of the correction counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets immediately, independent of clk).
- we3  input  1  write enable for port 3.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- wa3  input  5  write address, port 3.
- wd3  input  WIDTH  write data, port 3.
- rd1  output  WIDTH  voted read data, port 1.
- rd2  output  WIDTH  voted read data, port 2.
- scrub_en  input  1  enables the background scrubber.
- inj_en  input  1  fault-injection strobe.
- inj_copy  input  2  target copy, 0..2; value 3 is ignored.
- inj_addr  input  5  target register.
- inj_mask  input  WIDTH  bits to invert in the target entry.
- scrub_addr  output  5  register the scrubber is currently examining.
- corrected  output  1  one-cycle pulse after each completed repair.
- err_count  output  CNT_W  saturating count of completed repairs.
- err_copy_mask  output  3  sticky bit per copy; set when that copy has been repaired.

Behaviour:
- Reset (reset==0):
  - All entries of all three copies cleared to 0.
  - FSM set to SCAN, scrub_addr=1.
  - corrected=0, err_count=0, err_copy_mask=0.
- Reads:
  - Combinational, no latency.
  - rd = (c0&c1)|(c0&c2)|(c1&c2) per bit.
  - ra==0 returns 0.
- Writes:
  - we3=1 with wa3!=0 writes wd3 into all three copies at the clock edge.
  - wa3==0 is ignored.
- Injection:
  - inj_en=1 XORs inj_mask into copy[inj_copy][inj_addr] at the clock edge.
  - If it coincides with a functional write to the same entry, the XOR is applied after the write data (new value = wd3 ^ inj_mask in that copy).
  - inj_addr==0 or inj_copy==3 is ignored.
- Scrubber FSM, two states:
  - SCAN, scrub_en=0: hold; scrub_addr unchanged.
  - SCAN, scrub_en=1:
    - Compare the three copies at scrub_addr against their vote.
    - If all copies match, or we3 && wa3==scrub_addr this cycle (the write refreshes all copies): advance scrub_addr and stay in SCAN.
    - Otherwise: register the voted value and a 3-bit mismatch mask, then go to FIX with scrub_addr held.
  - FIX, no conflict:
    - At the edge ending FIX, write the registered voted value into each copy flagged in the mismatch mask.
    - err_count+1, saturating at all-ones.
    - err_copy_mask |= mismatch mask.
    - corrected=1 for exactly the next cycle.
  - FIX, conflict (we3 && wa3==scrub_addr, or inj_en && inj_addr==scrub_addr, in the FIX cycle):
    - Repair dropped; no count, no pulse.
    - The functional write or injection takes effect normally.
  - After FIX, in both cases: advance scrub_addr and return to SCAN.
  - scrub_en is ignored while in FIX; an entered FIX always completes.
- Address walk: 1,2,...,31,1,... Register 0 is never scrubbed.
- Worst-case sweep is 62 cycles with scrub_en held high.
- Reset asserted mid-FIX aborts the repair; the block returns to reset state.

Test Plan:
1. Apply reset=0 and release -> rd1=rd2=0, scrub_addr=1, err_count=0, err_copy_mask=3'b000, corrected=0.
2. Write r5=0xDEADBEEF; set ra1=5, ra2=0 -> rd1=0xDEADBEEF and rd2=0 in the same cycle as the address change. Writing wa3=0 with 0xFFFFFFFF leaves rd2=0.
3. With scrub_en=0, inject copy1 r5 mask 0x0000FFFF -> rd1 stays 0xDEADBEEF. Set scrub_en=1 -> within 62 cycles one corrected pulse, err_count=1, err_copy_mask=3'b010. Then inject copy2 r5 mask 0x0000FFFF -> rd1 still 0xDEADBEEF, which proves copy1 was repaired.
4. Inject copy0 r7 mask 0x1; when FIX is entered at scrub_addr=7, drive we3=1, wa3=7, wd3=0x12345678 in that cycle -> no corrected pulse, err_count unchanged, rd1(ra1=7)=0x12345678, scrub_addr advances to 8.
5. Build with CNT_W=2; inject four single-copy faults into r1..r4 and run a full sweep -> four corrected pulses, err_count saturates at 3.
6. Drive reset=0 while in FIX -> state SCAN, scrub_addr=1, err_count=0 with no clock edge required, and no repair is written.
